// File: rtl/axi4_mmio_intc_if.sv
// AXI4 slave-side bus bundle for the MMIO interrupt controller.
// The slave modport is used by the controller; the master modport by whoever drives it.
interface axi4_mmio_intc_if #(
    parameter int ADDR_W = 31,
    parameter int ID_W   = 5
);
    // Write address channel
    logic              s_awready;
    logic              s_awvalid;
    logic [ID_W-1:0]   s_awid;
    logic [ADDR_W-1:0] s_awaddr;
    logic [7:0]        s_awlen;
    logic [2:0]        s_awsize;
    logic [1:0]        s_awburst;
    logic              s_awlock;
    logic [3:0]        s_awcache;
    logic [2:0]        s_awprot;
    logic [3:0]        s_awqos;
    // Write data channel
    logic              s_wready;
    logic              s_wvalid;
    logic [63:0]       s_wdata;
    logic [7:0]        s_wstrb;
    logic              s_wlast;
    // Write response channel
    logic              s_bready;
    logic              s_bvalid;
    logic [ID_W-1:0]   s_bid;
    logic [1:0]        s_bresp;
    // Read address channel
    logic              s_arready;
    logic              s_arvalid;
    logic [ID_W-1:0]   s_arid;
    logic [ADDR_W-1:0] s_araddr;
    logic [7:0]        s_arlen;
    logic [2:0]        s_arsize;
    logic [1:0]        s_arburst;
    logic              s_arlock;
    logic [3:0]        s_arcache;
    logic [2:0]        s_arprot;
    logic [3:0]        s_arqos;
    // Read data channel
    logic              s_rready;
    logic              s_rvalid;
    logic [ID_W-1:0]   s_rid;
    logic [63:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;

    modport slave (
        output s_awready,
        input  s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst,
               s_awlock, s_awcache, s_awprot, s_awqos,
        output s_wready,
        input  s_wvalid, s_wdata, s_wstrb, s_wlast,
        input  s_bready,
        output s_bvalid, s_bid, s_bresp,
        output s_arready,
        input  s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst,
               s_arlock, s_arcache, s_arprot, s_arqos,
        input  s_rready,
        output s_rvalid, s_rid, s_rdata, s_rresp, s_rlast
    );

    modport master (
        input  s_awready,
        output s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst,
               s_awlock, s_awcache, s_awprot, s_awqos,
        input  s_wready,
        output s_wvalid, s_wdata, s_wstrb, s_wlast,
        output s_bready,
        input  s_bvalid, s_bid, s_bresp,
        input  s_arready,
        output s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst,
               s_arlock, s_arcache, s_arprot, s_arqos,
        output s_rready,
        input  s_rvalid, s_rid, s_rdata, s_rresp, s_rlast
    );
endinterface

// File: rtl/axi4_mmio_intc.sv
// AXI4 MMIO interrupt controller: latches edges on irq_src into pending bits and
// drives ext_intrs from pending & enable. Registers: 0x00 PENDING (RO),
// 0x08 ENABLE (RW), 0x10 CLEAR (W1C), 0x18 MODE. Offsets >= 0x20 answer DECERR.
// Optional level-sensitive sources via macro AXI4_INTC_LEVEL_MODE_EN; without it
// MODE reads 0 and all sources are edge-only.
module axi4_mmio_intc #(
    parameter int NUM_SRC  = 6,
    parameter int ADDR_W   = 31,
    parameter int ID_W     = 5,
    parameter int BASE_OFF = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic [NUM_SRC-1:0] ext_intrs,
    axi4_mmio_intc_if.slave    s
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [BASE_OFF-1:0] REG_END = BASE_OFF'(32);

    typedef enum logic [1:0] { W_IDLE, W_DATA, W_RESP } w_state_t;
    typedef enum logic       { R_IDLE, R_DATA } r_state_t;

    // Severity order DECERR > SLVERR > OKAY matches the numeric order of the codes.
    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        worst_resp = (a > b) ? a : b;
    endfunction

    function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) begin
            m[i*8 +: 8] = {8{strb[i]}};
        end
        strb_to_mask = m;
    endfunction

    // Source path state
    logic [NUM_SRC-1:0] sync1_r, sync2_r, prev_r, edge_s;
    logic [NUM_SRC-1:0] pending_r, enable_r, ext_intrs_r;
    logic [NUM_SRC-1:0] clr_s, pend_edge_s, pend_nxt_s, mode_rd_s;

    // Write channel state
    w_state_t          w_state_r;
    logic              awready_r, wready_r, bvalid_r;
    logic [ID_W-1:0]   bid_r;
    logic [1:0]        bresp_r, w_acc_r;
    logic [ADDR_W-1:0] waddr_r;
    logic [7:0]        w_cnt_r;
    logic [1:0]        w_burst_r;

    // Read channel state
    r_state_t          r_state_r;
    logic              arready_r, rvalid_r, rlast_r;
    logic [ID_W-1:0]   rid_r;
    logic [63:0]       rdata_r;
    logic [1:0]        rresp_r;
    logic [ADDR_W-1:0] raddr_r;
    logic [7:0]        r_cnt_r;
    logic [1:0]        r_burst_r;

    // Write beat decode
    logic                wr_fire_s, wr_dec_s, wr_last_err_s;
    logic [BASE_OFF-1:0] wr_off_s;
    logic [1:0]          wr_sel_s, wr_beat_resp_s;
    logic [63:0]         wr_mask64_s;
    logic [NUM_SRC-1:0]  wr_mask_s, wr_bits_s;

    // Read beat decode
    logic [ADDR_W-1:0]   rd_addr_s;
    logic [BASE_OFF-1:0] rd_off_s;
    logic [63:0]         rd_data_s;
    logic [1:0]          rd_resp_s;

    logic unused_s;

    assign wr_fire_s      = wready_r & s.s_wvalid;
    assign wr_off_s       = waddr_r[BASE_OFF-1:0];
    assign wr_dec_s       = (wr_off_s >= REG_END);
    assign wr_sel_s       = wr_off_s[4:3];
    assign wr_mask64_s    = strb_to_mask(s.s_wstrb);
    assign wr_mask_s      = wr_mask64_s[NUM_SRC-1:0];
    assign wr_bits_s      = s.s_wdata[NUM_SRC-1:0] & wr_mask_s;
    // wlast must be set exactly on the beat where the counter reaches zero.
    assign wr_last_err_s  = ((w_cnt_r == 8'd0) != s.s_wlast);
    assign wr_beat_resp_s = wr_dec_s ? RESP_DECERR : (wr_last_err_s ? RESP_SLVERR : RESP_OKAY);

    assign edge_s      = sync2_r & ~prev_r;
    assign pend_edge_s = (pending_r & ~clr_s) | edge_s;

    // CLEAR bits from the current write beat; strobe-masked so strb=0 clears nothing.
    always_comb begin
        clr_s = '0;
        if (wr_fire_s && !wr_dec_s && (wr_sel_s == 2'd2)) begin
            clr_s = wr_bits_s;
        end else begin
            clr_s = '0;
        end
    end

`ifdef AXI4_INTC_LEVEL_MODE_EN
    logic [NUM_SRC-1:0] mode_r;

    // MODE register: per-source level-sensitive select.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_r <= '0;
        end else if (wr_fire_s && !wr_dec_s && (wr_sel_s == 2'd3)) begin
            mode_r <= (mode_r & ~wr_mask_s) | wr_bits_s;
        end
    end

    assign mode_rd_s  = mode_r;
    // Level sources track the synchronized input, so CLEAR cannot drop them while high.
    assign pend_nxt_s = (pend_edge_s & ~mode_r) | (sync2_r & mode_r);
`else
    assign mode_rd_s  = '0;
    assign pend_nxt_s = pend_edge_s;
`endif

    // Synchronizer, edge history, pending, and registered interrupt outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r     <= '0;
            sync2_r     <= '0;
            prev_r      <= '0;
            pending_r   <= '0;
            ext_intrs_r <= '0;
        end else begin
            sync1_r     <= irq_src;
            sync2_r     <= sync1_r;
            prev_r      <= sync2_r;
            pending_r   <= pend_nxt_s;
            ext_intrs_r <= pending_r & enable_r;
        end
    end

    // ENABLE register with byte-strobe merge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enable_r <= '0;
        end else if (wr_fire_s && !wr_dec_s && (wr_sel_s == 2'd1)) begin
            enable_r <= (enable_r & ~wr_mask_s) | wr_bits_s;
        end
    end

    // Write FSM: address capture, data beats, then a single response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bid_r     <= '0;
            bresp_r   <= RESP_OKAY;
            w_acc_r   <= RESP_OKAY;
            waddr_r   <= '0;
            w_cnt_r   <= 8'd0;
            w_burst_r <= BURST_FIXED;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (awready_r && s.s_awvalid) begin
                        awready_r <= 1'b0;
                        wready_r  <= 1'b1;
                        bid_r     <= s.s_awid;
                        waddr_r   <= s.s_awaddr;
                        w_cnt_r   <= s.s_awlen;
                        w_burst_r <= s.s_awburst;
                        w_acc_r   <= RESP_OKAY;
                        w_state_r <= W_DATA;
                    end else begin
                        awready_r <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (wr_fire_s) begin
                        if (w_burst_r != BURST_FIXED) begin
                            waddr_r <= waddr_r + ADDR_W'(8);
                        end
                        if (w_cnt_r == 8'd0) begin
                            wready_r  <= 1'b0;
                            bvalid_r  <= 1'b1;
                            bresp_r   <= worst_resp(w_acc_r, wr_beat_resp_s);
                            w_state_r <= W_RESP;
                        end else begin
                            w_cnt_r <= w_cnt_r - 8'd1;
                            w_acc_r <= worst_resp(w_acc_r, wr_beat_resp_s);
                        end
                    end
                end
                W_RESP: begin
                    if (s.s_bready) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                    awready_r <= 1'b0;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Address of the beat to present next: the AR address, or the advanced burst address.
    always_comb begin
        rd_addr_s = raddr_r;
        if (r_state_r == R_IDLE) begin
            rd_addr_s = s.s_araddr;
        end else if (r_burst_r == BURST_FIXED) begin
            rd_addr_s = raddr_r;
        end else begin
            rd_addr_s = raddr_r + ADDR_W'(8);
        end
    end

    assign rd_off_s = rd_addr_s[BASE_OFF-1:0];

    // Register read mux; bits above NUM_SRC read as zero.
    always_comb begin
        rd_data_s = 64'd0;
        rd_resp_s = RESP_OKAY;
        if (rd_off_s >= REG_END) begin
            rd_resp_s = RESP_DECERR;
        end else begin
            case (rd_off_s[4:3])
                2'd0:    rd_data_s = 64'(pending_r);
                2'd1:    rd_data_s = 64'(enable_r);
                2'd2:    rd_data_s = 64'd0;
                2'd3:    rd_data_s = 64'(mode_rd_s);
                default: rd_data_s = 64'd0;
            endcase
        end
    end

    // Read FSM: R outputs are registered and only advance on an R handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rid_r     <= '0;
            rdata_r   <= 64'd0;
            rresp_r   <= RESP_OKAY;
            raddr_r   <= '0;
            r_cnt_r   <= 8'd0;
            r_burst_r <= BURST_FIXED;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (arready_r && s.s_arvalid) begin
                        arready_r <= 1'b0;
                        rid_r     <= s.s_arid;
                        raddr_r   <= s.s_araddr;
                        r_cnt_r   <= s.s_arlen;
                        r_burst_r <= s.s_arburst;
                        rvalid_r  <= 1'b1;
                        rdata_r   <= rd_data_s;
                        rresp_r   <= rd_resp_s;
                        rlast_r   <= (s.s_arlen == 8'd0);
                        r_state_r <= R_DATA;
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s.s_rready) begin
                        if (r_cnt_r == 8'd0) begin
                            rvalid_r  <= 1'b0;
                            rlast_r   <= 1'b0;
                            arready_r <= 1'b1;
                            r_state_r <= R_IDLE;
                        end else begin
                            raddr_r <= rd_addr_s;
                            r_cnt_r <= r_cnt_r - 8'd1;
                            rdata_r <= rd_data_s;
                            rresp_r <= rd_resp_s;
                            rlast_r <= (r_cnt_r == 8'd1);
                        end
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    arready_r <= 1'b0;
                    rvalid_r  <= 1'b0;
                    rlast_r   <= 1'b0;
                end
            endcase
        end
    end

    assign ext_intrs   = ext_intrs_r;
    assign s.s_awready = awready_r;
    assign s.s_wready  = wready_r;
    assign s.s_bvalid  = bvalid_r;
    assign s.s_bid     = bid_r;
    assign s.s_bresp   = bresp_r;
    assign s.s_arready = arready_r;
    assign s.s_rvalid  = rvalid_r;
    assign s.s_rid     = rid_r;
    assign s.s_rdata   = rdata_r;
    assign s.s_rresp   = rresp_r;
    assign s.s_rlast   = rlast_r;

    // Sideband fields that carry no meaning for this slave, plus address/data bits
    // outside the decoded range.
    assign unused_s = ^{s.s_awsize, s.s_awlock, s.s_awcache, s.s_awprot, s.s_awqos,
                        s.s_arsize, s.s_arlock, s.s_arcache, s.s_arprot, s.s_arqos,
                        s.s_wdata, waddr_r, rd_addr_s, wr_mask64_s};
endmodule
